// File: rtl/systolic_array_scharr_pkg.sv
// rtl/systolic_array_scharr_pkg.sv - shared types, coefficients and rounding helper for the Scharr cell
package systolic_array_scharr_pkg;

    typedef enum logic {SCHARR_X = 1'b0, SCHARR_Y = 1'b1} scharr_mode_t;

    localparam int SCHARR_C_OUTER = 3;
    localparam int SCHARR_C_INNER = 10;

    // Round half away from zero, then clamp to a signed (width+1)-bit range.
    function automatic logic signed [31:0] round_sat(input logic signed [31:0] sum,
                                                     input int shift,
                                                     input int width);
        logic signed [31:0] mag;
        logic signed [31:0] q;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        mag = (sum < 0) ? -sum : sum;
        if (shift > 0) begin
            q = (mag + (32'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            q = mag;
        end
        if (sum < 0) begin
            q = -q;
        end
        hi = (32'sd1 <<< width) - 32'sd1;
        lo = -(32'sd1 <<< width);
        if (q > hi) begin
            q = hi;
        end else if (q < lo) begin
            q = lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/systolic_array_scharr_row_window.sv
// rtl/systolic_array_scharr_row_window.sv - 3-tap enable-gated pixel shift register for one image row
module systolic_array_scharr_row_window #(
    parameter int p_data_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [p_data_width-1:0] x,
    output logic [p_data_width-1:0] c0,
    output logic [p_data_width-1:0] c1,
    output logic [p_data_width-1:0] c2
);

    always_ff @(posedge clk) begin
        if (reset) begin
            c0 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (en) begin
            c0 <= c1;
            c1 <= c2;
            c2 <= x;
        end
    end

endmodule

// File: rtl/systolic_array_scharr_grad_cell.sv
// rtl/systolic_array_scharr_grad_cell.sv - streaming 3x3 Scharr X/Y gradient cell with valid/ready handshake
module systolic_array_scharr_grad_cell
    import systolic_array_scharr_pkg::*;
#(
    parameter int p_data_width = 8,
    parameter int p_shift      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [p_data_width-1:0] x1,
    input  logic [p_data_width-1:0] x2,
    input  logic [p_data_width-1:0] x3,
    input  logic                    new_row,
    input  logic                    mode,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_data_width:0]   result
);

    localparam int SW = p_data_width + 6;

    logic [p_data_width-1:0] r1c0, r1c1, r1c2;
    logic [p_data_width-1:0] r2c0, r2c1, r2c2;
    logic [p_data_width-1:0] r3c0, r3c1, r3c2;
    logic                    beat;
    logic                    produce;
    logic [1:0]              count;
    scharr_mode_t            mode_q;
    logic signed [SW-1:0]    s1_0, s1_1, s1_2, s2_0, s2_2, s3_0, s3_1, s3_2;
    logic signed [SW-1:0]    d_a, d_m, d_b;
    logic signed [SW-1:0]    sum;
    logic signed [31:0]      q_full;
    logic                    unused_bits;

    assign in_rdy  = out_rdy || !out_val;
    assign beat    = in_val && in_rdy;
    assign produce = beat && !new_row && (count == 2'd2);

    systolic_array_scharr_row_window #(.p_data_width(p_data_width)) u_row1 (
        .clk(clk), .reset(reset), .en(beat), .x(x1), .c0(r1c0), .c1(r1c1), .c2(r1c2));
    systolic_array_scharr_row_window #(.p_data_width(p_data_width)) u_row2 (
        .clk(clk), .reset(reset), .en(beat), .x(x2), .c0(r2c0), .c1(r2c1), .c2(r2c2));
    systolic_array_scharr_row_window #(.p_data_width(p_data_width)) u_row3 (
        .clk(clk), .reset(reset), .en(beat), .x(x3), .c0(r3c0), .c1(r3c1), .c2(r3c2));

    // The datapath works on the window as it will be after this beat's shift.
    assign s1_0 = $signed({6'b0, r1c1});
    assign s1_1 = $signed({6'b0, r1c2});
    assign s1_2 = $signed({6'b0, x1});
    assign s2_0 = $signed({6'b0, r2c1});
    assign s2_2 = $signed({6'b0, x2});
    assign s3_0 = $signed({6'b0, r3c1});
    assign s3_1 = $signed({6'b0, r3c2});
    assign s3_2 = $signed({6'b0, x3});

    always_comb begin
        d_a = s1_2 - s1_0;
        d_m = s2_2 - s2_0;
        d_b = s3_2 - s3_0;
        if (mode_q == SCHARR_Y) begin
            d_a = s3_0 - s1_0;
            d_m = s3_1 - s1_1;
            d_b = s3_2 - s1_2;
        end
    end

    assign sum    = ((d_a <<< 1) + d_a) + ((d_m <<< 3) + (d_m <<< 1)) + ((d_b <<< 1) + d_b);
    assign q_full = round_sat(32'(sum), p_shift, p_data_width);

    assign unused_bits = ^{r1c0, r2c0, r3c0, r2c2, q_full[31:p_data_width+1]};

    // A new_row beat is column 0 of the row and already counts as the first fill step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            mode_q <= SCHARR_X;
        end else if (beat) begin
            if (new_row) begin
                count  <= 2'd1;
                mode_q <= scharr_mode_t'(mode);
            end else if (count != 2'd2) begin
                count <= count + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_val <= 1'b0;
            result  <= '0;
        end else if (produce) begin
            out_val <= 1'b1;
            result  <= q_full[p_data_width:0];
        end else if (out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_array_scharr_grad_cell.sv
// tb/tb_systolic_array_scharr_grad_cell.sv - directed vector bench for the Scharr gradient cell
module tb_systolic_array_scharr_grad_cell;
    import systolic_array_scharr_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [7:0] x1 = '0, x2 = '0, x3 = '0;
    logic       new_row = 1'b0;
    logic       mode = 1'b0;
    logic       out_val;
    logic       out_rdy = 1'b1;
    logic [8:0] result;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic       nr;
        logic       md;
        logic [7:0] a, b, c;
        logic       ev;
        logic [8:0] er;
    } vec_t;

    vec_t vecs[$];

    systolic_array_scharr_grad_cell #(.p_data_width(8), .p_shift(5)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
        .x1(x1), .x2(x2), .x3(x3), .new_row(new_row), .mode(mode),
        .out_val(out_val), .out_rdy(out_rdy), .result(result));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic nr, input logic md, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic ev, input logic [8:0] er);
        vec_t v;
        v.nr = nr; v.md = md; v.a = a; v.b = b; v.c = c; v.ev = ev; v.er = er;
        vecs.push_back(v);
    endtask

    // X gradient of a column pair where all three rows carry the same pixel.
    function automatic logic [8:0] model_x(input int left, input int right);
        int s, m, q;
        s = (2 * SCHARR_C_OUTER + SCHARR_C_INNER) * (right - left);
        m = (s < 0) ? -s : s;
        q = (m + 16) / 32;
        if (s < 0) q = -q;
        return 9'(q);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_val = 1'b0; new_row = 1'b0; out_rdy = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] cols [6];
        logic [8:0] got [$];
        logic [8:0] exp_bp [4];
        int         idx;
        logic       beat;

        // flat rows, X then Y
        add(1, 0, 255, 255, 255, 0, 0); add(0, 0, 255, 255, 255, 0, 0);
        add(0, 0, 255, 255, 255, 1, 0); add(0, 0, 255, 255, 255, 1, 0); add(0, 0, 255, 255, 255, 1, 0);
        add(1, 1, 255, 255, 255, 0, 0); add(0, 1, 255, 255, 255, 0, 0);
        add(0, 1, 255, 255, 255, 1, 0); add(0, 1, 255, 255, 255, 1, 0); add(0, 1, 255, 255, 255, 1, 0);
        // Y step; mode toggled mid-row must be ignored
        add(1, 1, 0, 0, 255, 0, 0); add(0, 0, 0, 0, 255, 0, 0); add(0, 0, 0, 0, 255, 1, 9'h080);
        add(1, 1, 255, 0, 0, 0, 0); add(0, 1, 255, 0, 0, 0, 0); add(0, 1, 255, 0, 0, 1, 9'h180);
        // X step and its reverse
        add(1, 0, 0, 0, 0, 0, 0); add(0, 0, 9, 9, 9, 0, 0); add(0, 0, 255, 255, 255, 1, 9'h080);
        add(1, 0, 255, 255, 255, 0, 0); add(0, 0, 9, 9, 9, 0, 0); add(0, 0, 0, 0, 0, 1, 9'h180);
        // rounding ties and sub-half sums
        add(1, 1, 0, 0, 2, 0, 0); add(0, 1, 0, 0, 1, 0, 0); add(0, 1, 0, 0, 0, 1, 9'h001);
        add(1, 1, 2, 0, 0, 0, 0); add(0, 1, 1, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1, 9'h1FF);
        add(1, 1, 0, 0, 5, 0, 0); add(0, 1, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 1, 9'h000);
        // sliding X window: 480->15, 960->30, 1920->60
        add(1, 0, 10, 10, 10, 0, 0); add(0, 0, 20, 20, 20, 0, 0); add(0, 0, 40, 40, 40, 1, 15);
        add(0, 0, 80, 80, 80, 1, 30); add(0, 0, 160, 160, 160, 1, 60);
        // new_row on beat 2 restarts the window in Y: sum 3315 -> 104
        add(1, 0, 255, 255, 255, 0, 0); add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 255, 0, 0); add(0, 1, 0, 0, 255, 1, 104);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_out_val", out_val, 0);
        check("reset_result", result, 0);
        check("reset_in_rdy", in_rdy, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_val = 1'b1; out_rdy = 1'b1;
            new_row = vecs[i].nr; mode = vecs[i].md;
            x1 = vecs[i].a; x2 = vecs[i].b; x3 = vecs[i].c;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_val", i), out_val, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("vec%0d_res", i), result, vecs[i].er);
        end

        // backpressure: consumer stalls for 4 cycles after the first result
        idle(3);
        cols = '{10, 20, 40, 80, 160, 250};
        for (int k = 0; k < 4; k++) exp_bp[k] = model_x(cols[k], cols[k + 2]);
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_rdy = !(cyc >= 3 && cyc <= 6);
            if (idx < 6) begin
                in_val = 1'b1; new_row = (idx == 0); mode = 1'b0;
                x1 = cols[idx]; x2 = cols[idx]; x3 = cols[idx];
            end else begin
                in_val = 1'b0; new_row = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                check($sformatf("bp_in_rdy_c%0d", cyc), in_rdy, 0);
                check($sformatf("bp_hold_val_c%0d", cyc), out_val, 1);
                check($sformatf("bp_hold_res_c%0d", cyc), result, exp_bp[0]);
            end
            if (out_val && out_rdy) got.push_back(result);
            beat = in_val && in_rdy;
            @(posedge clk);
            if (beat) idx++;
        end
        check("bp_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            check($sformatf("bp_res%0d", k), got[k], exp_bp[k]);

        // reset mid-row with a pending result, then restart without new_row
        idle(2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_val = 1'b1; new_row = (k == 0); mode = 1'b1;
            x1 = 8'd0; x2 = 8'd0; x3 = 8'd255;
        end
        @(negedge clk);
        out_rdy = 1'b0; in_val = 1'b0; new_row = 1'b0;
        #1;
        check("pre_reset_val", out_val, 1);
        @(negedge clk);
        reset = 1'b1; in_val = 1'b1; x1 = 8'd77; x2 = 8'd77; x3 = 8'd77;
        @(negedge clk);
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
        #1;
        check("mid_reset_val", out_val, 0);
        check("mid_reset_res", result, 0);
        check("mid_reset_in_rdy", in_rdy, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_val = 1'b1; new_row = 1'b0; mode = 1'b1;
            x1 = (k == 2) ? 8'd32 : 8'd0; x2 = x1; x3 = x1;
            @(posedge clk);
            #1;
            check($sformatf("restart_val%0d", k), out_val, (k == 2));
        end
        check("restart_res_x", result, 9'd16);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
